// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_pkg                                                    |
// | Purpose  : Shared types and constants for the 4x4 keypad scanner:       |
// |            scanner state enum, matrix geometry, key-code width, output  |
// |            queue depth, and the row-priority key-code helper.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_W      = 4;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Code of the pressed key: the lowest-index low row wins when several
  // rows are pulled low on the same column; code = row*4 + col.
  function automatic logic [KEY_W-1:0] key_code(input logic [NUM_ROWS-1:0] rows,
                                                input logic [1:0]          col);
    logic [1:0] row;
    row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) row = 2'(i);
    end
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_fifo                                                      |
// | Purpose  : FIFO_DEPTH x KEY_W queue for debounced key codes with        |
// |            registered empty/full flags and a sticky overrun flag.       |
// |            Only present when KEYPAD_FIFO_EN is defined.                 |
// | Ports    : clk, rst      - clock, asynchronous active-high reset        |
// |            i_push/i_code - new key code from the scanner                |
// |            i_pop         - consumer ready (pops head when non-empty)    |
// |            o_valid/o_code- queue non-empty / head entry                 |
// |            o_overrun     - a code arrived while full with no pop        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`ifdef KEYPAD_FIFO_EN
module key_fifo
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [KEY_W-1:0] i_code,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [KEY_W-1:0] o_code,
  output logic             o_overrun
);

  localparam int                c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_full_cnt = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [KEY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_empty;
  logic               r_full;
  logic               r_overrun;
  logic               w_do_pop;
  logic               w_do_push;
  logic [c_ptr_w:0]   w_count_nxt;

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted when the consumer is draining.
  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_full_cnt);
      if (i_push && !w_do_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_valid   = !r_empty;
  assign o_code    = r_mem[r_rd_ptr];
  assign o_overrun = r_overrun;

endmodule
`endif
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_scan_ctrl                                              |
// | Purpose  : 4x4 matrix keypad scanner. Drives one active-low column at a |
// |            time, synchronizes the active-low rows, debounces press and  |
// |            release, and hands out one key code per physical press over |
// |            a valid/ready interface.                                     |
// | Ports    : clk, rst     - clock, asynchronous active-high reset         |
// |            row_i        - keypad rows (active-low, asynchronous)        |
// |            col_o        - column drive (active-low, one bit low)        |
// |            key_code_o   - key code, row*4 + col                         |
// |            key_valid_o  - key code available                            |
// |            key_ready_i  - consumer accepts the code                     |
// |            overrun_o    - sticky: a debounced key was dropped           |
// | Config   : KEYPAD_FIFO_EN - queue codes in a 4-entry FIFO instead of a  |
// |            single output register                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 270,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  output logic [KEY_W-1:0]    key_code_o,
  output logic                key_valid_o,
  input  logic                key_ready_i,
  output logic                overrun_o
);

  localparam int c_cnt_max = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] r_row_meta;
  logic [NUM_ROWS-1:0] r_rows_s;
  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [1:0]          r_col;
  logic [1:0]          w_col_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [NUM_ROWS-1:0] r_pattern;
  logic [NUM_ROWS-1:0] w_pattern_nxt;
  logic                w_push;
  logic [KEY_W-1:0]    w_push_code;

  // Two-flop row synchronizer; idles high (no key) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_rows_s   <= '1;
    end else begin
      r_row_meta <= row_i;
      r_rows_s   <= r_row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCAN;
      r_col     <= 2'd0;
      r_cnt     <= '0;
      r_pattern <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pattern <= w_pattern_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_cnt_nxt     = r_cnt;
    w_pattern_nxt = r_pattern;
    w_push        = 1'b0;
    case (r_state)
      SCAN: begin
        // Rows are only trusted after the column has settled for the full
        // scan period, which also covers the synchronizer latency.
        if (r_cnt == c_scan_last) begin
          w_cnt_nxt = '0;
          if (r_rows_s == '1) begin
            w_col_nxt = r_col + 2'd1;
          end else begin
            w_pattern_nxt = r_rows_s;
            w_state_nxt   = DEBOUNCE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (r_rows_s != r_pattern) begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_push      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (r_rows_s == '1) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        // A row dropping low again is release bounce, not a new press.
        if (r_rows_s != '1) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt = SCAN;
          w_col_nxt   = r_col + 2'd1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign col_o       = ~(4'b0001 << r_col);
  assign w_push_code = key_code(r_pattern, r_col);

`ifdef KEYPAD_FIFO_EN
  key_fifo u_key_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_code    (w_push_code),
    .i_pop     (key_ready_i),
    .o_valid   (key_valid_o),
    .o_code    (key_code_o),
    .o_overrun (overrun_o)
  );
`else
  logic             r_valid;
  logic [KEY_W-1:0] r_code;
  logic             r_overrun;

  // A new code is taken when the register is empty or being emptied this
  // cycle; otherwise the old code is kept and the new one is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        if (!r_valid || key_ready_i) begin
          r_code  <= w_push_code;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && key_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign key_valid_o = r_valid;
  assign key_code_o  = r_code;
  assign overrun_o   = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_scan_ctrl                                           |
// | Purpose  : Self-checking bench for keypad_scan_ctrl. A behavioural 4x4  |
// |            keypad pulls rows low from the driven column; expected codes |
// |            come from the press itself (lowest row * 4 + column) and are |
// |            matched against every valid/ready transfer.                  |
// | Config   : KEYPAD_FIFO_EN - expectations for the queued output build   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_keypad_scan_ctrl;

  localparam int c_scan = 4;
  localparam int c_deb  = 8;
`ifdef KEYPAD_FIFO_EN
  localparam bit c_fifo = 1'b1;
`else
  localparam bit c_fifo = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_ready_i = 1'b1;
  logic       overrun_o;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          exp_q[$];
  bit          rand_ready = 1'b0;
  bit          ready_fixed = 1'b1;
  bit          prev_valid = 1'b0;
  bit          prev_xfer = 1'b0;
  logic [3:0]  prev_code = '0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_CYCLES     (c_scan),
    .DEBOUNCE_CYCLES (c_deb)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (key_ready_i),
    .overrun_o   (overrun_o)
  );

  // Physical keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, then drive ready for the next rising edge.
  task automatic step();
    @(negedge clk);
    if (prev_valid && !prev_xfer) begin
      check("hold_valid", key_valid_o, 1);
      check("hold_code", key_code_o, prev_code);
    end
    key_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    prev_xfer = key_valid_o && key_ready_i;
    if (prev_xfer) begin
      check("xfer_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("xfer_code", key_code_o, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    prev_valid = key_valid_o;
    prev_code  = key_code_o;
  endtask

  // Rows idle: columns rotate every c_scan cycles starting at column 0; call right after reset release.
  task automatic idle_check();
    logic [3:0] exp_col;
    for (int i = 1; i <= 40; i++) begin
      step();
      exp_col = 4'hF;
      exp_col[(i / c_scan) % 4] = 1'b0;
      check("idle_col", col_o, exp_col);
      check("idle_valid", key_valid_o, 0);
    end
  endtask

  task automatic press(input logic [3:0] mask, input int col, input bit b_in, input bit b_out,
                       input int hold, input bit expect_code, input bit final_chk);
    logic [15:0] pat;
    int          row;
    pat = '0;
    row = 0;
    for (int r = 3; r >= 0; r--) begin
      if (mask[r]) begin
        pat[r*4+col] = 1'b1;
        row = r;
      end
    end
    if (b_in) begin
      for (int i = 0; i < 15; i++) begin
        if (i % 3 == 0) pressed = pressed ^ pat;
        step();
        check("bounce_no_valid", key_valid_o, 0);
      end
    end
    if (expect_code) exp_q.push_back(row * 4 + col);
    pressed = pressed | pat;
    repeat (hold) step();
    if (b_out) begin
      for (int i = 0; i < 12; i++) begin
        if (i % 3 == 0) pressed = pressed ^ pat;
        step();
      end
    end
    pressed = '0;
    repeat (30) step();
    if (final_chk) begin
      check("all_delivered", exp_q.size(), 0);
      check("no_overrun", overrun_o, 0);
    end
  endtask

  initial begin
    int t0;
    int t1;
    #1 rst = 1'b1;
    #1;
    check("rst_col", col_o, 4'b1110);
    check("rst_valid", key_valid_o, 0);
    check("rst_code", key_code_o, 0);
    check("rst_overrun", overrun_o, 0);
    repeat (2) step();
    rst = 1'b0;
    idle_check();

    // Row 2 on column 1: exact latency from the column switch, one code only.
    for (int i = 0; i < 20 && col_o != 4'b1110; i++) step();
    check("sync_col0", col_o, 4'b1110);
    exp_q.push_back(9);
    pressed[2*4+1] = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (t0 < 0 && col_o == 4'b1101) t0 = i;
      if (t1 < 0 && key_valid_o) t1 = i;
    end
    check("latency", t1 - t0, c_scan + c_deb);
    pressed = '0;
    repeat (30) step();
    check("code9_delivered", exp_q.size(), 0);

    press(4'b0001, 0, 1'b1, 1'b0, 40, 1'b1, 1'b1);   // bounce then code 0
    press(4'b1001, 2, 1'b0, 1'b0, 40, 1'b1, 1'b1);   // rows 0 and 3 -> code 2

    rand_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      press(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(40, 70), 1'b1, 1'b1);
    end
    rand_ready  = 1'b0;

    // Consumer stalled: code 5 then code 6.
    ready_fixed = 1'b0;
    press(4'b0010, 1, 1'b0, 1'b0, 40, 1'b1, 1'b0);
    press(4'b0010, 2, 1'b0, 1'b0, 40, c_fifo, 1'b0);
    check("ovr_valid", key_valid_o, 1);
    check("ovr_code", key_code_o, 5);
    check("ovr_flag", overrun_o, c_fifo ? 0 : 1);
    ready_fixed = 1'b1;
    repeat (10) step();
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_valid_low", key_valid_o, 0);

    // Reset while a code is held: pending key discarded, scanning restarts.
    ready_fixed = 1'b0;
    pressed[15] = 1'b1;
    for (int i = 0; i < 80 && !key_valid_o; i++) step();
    check("pre_rst_valid", key_valid_o, 1);
    check("pre_rst_code", key_code_o, 15);
    repeat (3) step();
    #2 rst = 1'b1;
    prev_valid = 1'b0;
    #1;
    check("mid_rst_col", col_o, 4'b1110);
    check("mid_rst_valid", key_valid_o, 0);
    check("mid_rst_code", key_code_o, 0);
    check("mid_rst_overrun", overrun_o, 0);
    repeat (3) step();
    pressed = '0;
    ready_fixed = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    idle_check();
    check("post_rst_none", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
